// File: rtl/key_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module   : key_matrix_scan
//  Purpose  : Scans a 4x4 active-low matrix keypad. Debounces press and
//             release on a slow scan tick and reports each press once as a
//             4-bit code {row_idx, col_idx} with a one-cycle strobe.
//  Ports    : clk          system clock
//             rst_n        asynchronous active-low reset
//             col_i[3:0]   keypad columns (pulled up, low = contact)
//             row_o[3:0]   keypad rows, driven low to select
//             key_valid_o  one-cycle strobe, key_code_o holds a new press
//             key_code_o   {row_idx[1:0], col_idx[1:0]}, held until next strobe
//             key_held_o   high from the strobe until the release is debounced
//  Revision : 1.0  initial release
// ============================================================================
module key_matrix_scan #(
  parameter int SCAN_DIV = 50_000,  // clk cycles per scan tick, >= 4
  parameter int DEB_CNT  = 20       // stable ticks needed for press/release
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  output logic       key_held_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEB    = 3'd1,
    S_SCAN   = 3'd2,
    S_REPORT = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, col_s_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_held_q;

  logic             tick;
  logic             col_low;
  logic [1:0]       col_idx;

  // Two-flop synchroniser; idles high so reset looks like "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      col_s_q <= 4'hF;
    end else begin
      sync1_q <= col_i;
      col_s_q <= sync1_q;
    end
  end

  // Free-running scan divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (div_q == DIV_MAX) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick    = (div_q == DIV_MAX);
  assign col_low = (col_s_q != 4'hF);

  // Lowest-index low column wins within the selected row.
  always_comb begin
    col_idx = 2'd0;
    if (!col_s_q[0])      col_idx = 2'd0;
    else if (!col_s_q[1]) col_idx = 2'd1;
    else if (!col_s_q[2]) col_idx = 2'd2;
    else if (!col_s_q[3]) col_idx = 2'd3;
  end

  // Counters stop at CNT_MAX because the transition fires there, so they
  // can never wrap.
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    row_idx_d  = row_idx_q;
    key_code_d = key_code_q;
    case (state_q)
      S_IDLE: begin
        if (tick && col_low) begin
          state_d   = S_DEB;
          deb_cnt_d = '0;
        end
      end
      S_DEB: begin
        if (tick) begin
          if (!col_low) begin
            state_d = S_IDLE;
          end else if (deb_cnt_q == CNT_MAX) begin
            state_d   = S_SCAN;
            row_idx_d = 2'd0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
      end
      S_SCAN: begin
        // Each row has been driven for a whole tick when col_s is sampled here.
        if (tick) begin
          if (col_low) begin
            key_code_d = {row_idx_q, col_idx};
            state_d    = S_REPORT;
          end else if (row_idx_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
      end
      S_REPORT: begin
        state_d   = S_HOLD;
        rel_cnt_d = '0;
      end
      S_HOLD: begin
        // Any contact, including a second key, restarts release debounce.
        if (tick) begin
          if (col_low) begin
            rel_cnt_d = '0;
          end else if (rel_cnt_q == CNT_MAX) begin
            state_d   = S_IDLE;
            rel_cnt_d = '0;
          end else begin
            rel_cnt_d = rel_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      row_idx_q   <= 2'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      // Strobe and held flag are aligned with the REPORT cycle.
      key_valid_q <= (state_d == S_REPORT);
      key_held_q  <= (state_d == S_REPORT) || (state_d == S_HOLD);
    end
  end

  // All rows selected except while walking them one at a time.
  assign row_o       = (state_q == S_SCAN) ? ~(4'b0001 << row_idx_q) : 4'b0000;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign key_held_o  = key_held_q;

endmodule
`default_nettype wire
